iq_dispatch: RTL and testbench

- Sequencer between `instruction_queue` and the three execution units: DMA engine, math unit and cache/regfile unit.
- Pops one instruction at a time and routes it by type to the matching unit over a valid/ready handshake.
- Enforces two ordering rules:
  - caps the number of in-flight DMA transfers;
  - fences cache instructions behind outstanding DMA.

---
 rtl/iq_dispatch_pkg.sv | 49 ++++
 rtl/iq_dispatch_if.sv | 47 ++++
 rtl/iq_dispatch_dma_credit_counter.sv | 42 ++++
 rtl/iq_dispatch.sv | 166 ++++++++++++++++
 tb/tb_iq_dispatch.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iq_dispatch_pkg.sv
// Shared types for the instruction-queue dispatcher: instruction types,
// dispatch FSM states and the instruction payload structs used by the units.
package iq_dispatch_pkg;

    typedef enum logic [1:0] {
        INSTR_TYPE_DMA        = 2'b00,
        INSTR_TYPE_ARITHMETIC = 2'b01,
        INSTR_TYPE_LD_ST      = 2'b10,
        INSTR_TYPE_RSVD       = 2'b11
    } instr_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        ISSUE = 2'd2
    } dispatch_state_e;

    typedef enum logic [3:0] {
        MATH_ADD  = 4'd0,
        MATH_SUB  = 4'd1,
        MATH_MUL  = 4'd2,
        MATH_RELU = 4'd3
    } math_op_e;

    typedef struct packed {
        logic [15:0] srcAddr;
        logic [15:0] dstAddr;
        logic [7:0]  length;
    } dma_instruction;

    typedef struct packed {
        math_op_e    op;
        logic [9:0]  operand;
    } math_instr;

    typedef struct packed {
        logic        isStore;
        logic [4:0]  regIdx;
        logic [15:0] addr;
    } regfile_instruction;

    localparam int PERF_CNT_W = 32;

    // Saturating increment shared by the optional performance counters.
    function automatic logic [PERF_CNT_W-1:0] satInc(input logic [PERF_CNT_W-1:0] value);
        return (value == '1) ? value : value + PERF_CNT_W'(1);
    endfunction

endpackage

// File: rtl/iq_dispatch_if.sv
// Handshake bundle between the dispatcher, the instruction queue and the
// DMA / math / cache execution units.
interface iq_dispatch_if;

    logic                                  iq_re;
    logic                                  iq_empty;
    iq_dispatch_pkg::instr_type_e          iq_instr_type;
    iq_dispatch_pkg::dma_instruction       iq_dma_instr;
    iq_dispatch_pkg::math_instr            iq_math_instr;
    iq_dispatch_pkg::regfile_instruction   iq_cache_instr;

    logic                                  dma_valid;
    logic                                  dma_ready;
    logic                                  dma_done;
    iq_dispatch_pkg::dma_instruction       dma_instr;

    logic                                  math_valid;
    logic                                  math_ready;
    iq_dispatch_pkg::math_instr            math_instr;

    logic                                  cache_valid;
    logic                                  cache_ready;
    iq_dispatch_pkg::regfile_instruction   cache_instr;

    modport master (
        output iq_re,
        input  iq_empty, iq_instr_type, iq_dma_instr, iq_math_instr, iq_cache_instr,
        output dma_valid, dma_instr,
        input  dma_ready, dma_done,
        output math_valid, math_instr,
        input  math_ready,
        output cache_valid, cache_instr,
        input  cache_ready
    );

    modport slave (
        input  iq_re,
        output iq_empty, iq_instr_type, iq_dma_instr, iq_math_instr, iq_cache_instr,
        input  dma_valid, dma_instr,
        output dma_ready, dma_done,
        input  math_valid, math_instr,
        output math_ready,
        input  cache_valid, cache_instr,
        output cache_ready
    );

endinterface

// File: rtl/iq_dispatch_dma_credit_counter.sv
// Up/down count of DMA transfers issued but not yet completed, with full and
// empty status and an underflow pulse when a completion arrives at zero.
module dma_credit_counter #(
    parameter  int DMA_MAX_OUTSTANDING = 4,
    localparam int CW = $clog2(DMA_MAX_OUTSTANDING + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          zero_o,
    output logic          underflow_o
);

    logic [CW-1:0] count_q, count_d;

    // A simultaneous issue and completion cancel out; a stray completion at zero is ignored.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i) begin
            count_d = count_q + CW'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign full_o      = (count_q >= CW'(DMA_MAX_OUTSTANDING));
    assign zero_o      = (count_q == '0);
    assign underflow_o = dec_i && zero_o;

endmodule

// File: rtl/iq_dispatch.sv
// Pops instructions from the queue and issues each to its execution unit,
// capping in-flight DMA and fencing cache ops behind DMA. Optional perf
// counters are built when IQ_DISPATCH_PERF_EN is defined.
module iq_dispatch
    import iq_dispatch_pkg::*;
#(
    parameter  int DMA_MAX_OUTSTANDING = 4,
    localparam int CW = $clog2(DMA_MAX_OUTSTANDING + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    iq_dispatch_if.master        bus,
    output logic [CW-1:0]        dma_outstanding_o,
    output logic                 busy_o,
    output logic                 err_o
`ifdef IQ_DISPATCH_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_dma_cycles_o,
    output logic [PERF_CNT_W-1:0] stall_cache_cycles_o,
    output logic [PERF_CNT_W-1:0] issued_count_o
`endif
);

    dispatch_state_e    state_q, state_d;
    instr_type_e        holdType_q;
    dma_instruction     holdDma_q;
    math_instr          holdMath_q;
    regfile_instruction holdCache_q;
    logic               err_q;

    logic iqRe, dmaValid, mathValid, cacheValid, handshakeDone, rsvdDrop;
    logic dmaIssue, dmaFull, dmaZero, dmaUnderflow;

    assign dmaIssue = dmaValid && bus.dma_ready;

    dma_credit_counter #(
        .DMA_MAX_OUTSTANDING(DMA_MAX_OUTSTANDING)
    ) u_credit (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_i       (dmaIssue),
        .dec_i       (bus.dma_done),
        .count_o     (dma_outstanding_o),
        .full_o      (dmaFull),
        .zero_o      (dmaZero),
        .underflow_o (dmaUnderflow)
    );

    // Gates only relax while in ISSUE: the credit count cannot rise without our own handshake.
    always_comb begin
        state_d       = state_q;
        iqRe          = 1'b0;
        dmaValid      = 1'b0;
        mathValid     = 1'b0;
        cacheValid    = 1'b0;
        handshakeDone = 1'b0;
        rsvdDrop      = 1'b0;
        case (state_q)
            IDLE: begin
                iqRe = !bus.iq_empty;
                if (!bus.iq_empty) begin
                    state_d = RD;
                end
            end
            RD: begin
                state_d = ISSUE;
            end
            ISSUE: begin
                case (holdType_q)
                    INSTR_TYPE_DMA: begin
                        dmaValid      = !dmaFull;
                        handshakeDone = dmaValid && bus.dma_ready;
                    end
                    INSTR_TYPE_ARITHMETIC: begin
                        mathValid     = 1'b1;
                        handshakeDone = bus.math_ready;
                    end
                    INSTR_TYPE_LD_ST: begin
                        cacheValid    = dmaZero;
                        handshakeDone = cacheValid && bus.cache_ready;
                    end
                    default: begin
                        rsvdDrop      = 1'b1;
                        handshakeDone = 1'b1;
                    end
                endcase
                if (handshakeDone) begin
                    iqRe    = !bus.iq_empty;
                    state_d = bus.iq_empty ? IDLE : RD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Queue data is valid the cycle after the pop, which is exactly the RD state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdType_q  <= INSTR_TYPE_DMA;
            holdDma_q   <= '0;
            holdMath_q  <= '0;
            holdCache_q <= '0;
        end else if (state_q == RD) begin
            holdType_q  <= bus.iq_instr_type;
            holdDma_q   <= bus.iq_dma_instr;
            holdMath_q  <= bus.iq_math_instr;
            holdCache_q <= bus.iq_cache_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (rsvdDrop || dmaUnderflow) begin
            err_q <= 1'b1;
        end
    end

    assign bus.iq_re       = iqRe;
    assign bus.dma_valid   = dmaValid;
    assign bus.dma_instr   = holdDma_q;
    assign bus.math_valid  = mathValid;
    assign bus.math_instr  = holdMath_q;
    assign bus.cache_valid = cacheValid;
    assign bus.cache_instr = holdCache_q;

    assign busy_o = (state_q != IDLE) || !dmaZero;
    assign err_o  = err_q;

`ifdef IQ_DISPATCH_PERF_EN
    logic [PERF_CNT_W-1:0] stallDma_q, stallCache_q, issued_q;
    logic stallDma, stallCache, issued;

    assign stallDma   = (state_q == ISSUE) && (holdType_q == INSTR_TYPE_DMA) && !dmaIssue;
    assign stallCache = (state_q == ISSUE) && (holdType_q == INSTR_TYPE_LD_ST)
                        && !(cacheValid && bus.cache_ready);
    assign issued     = dmaIssue || (mathValid && bus.math_ready) || (cacheValid && bus.cache_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallDma_q   <= '0;
            stallCache_q <= '0;
            issued_q     <= '0;
        end else begin
            if (stallDma)   stallDma_q   <= satInc(stallDma_q);
            if (stallCache) stallCache_q <= satInc(stallCache_q);
            if (issued)     issued_q     <= satInc(issued_q);
        end
    end

    assign stall_dma_cycles_o   = stallDma_q;
    assign stall_cache_cycles_o = stallCache_q;
    assign issued_count_o       = issued_q;
`endif

endmodule

// File: tb/tb_iq_dispatch.sv
// Scoreboard bench for iq_dispatch: a FIFO model of the queue feeds the DUT and
// every unit handshake is matched against the expected in-order issue stream.
module tb_iq_dispatch;
    import iq_dispatch_pkg::*;

    localparam int MAX_OUT = 4;
    localparam int CW = $clog2(MAX_OUT + 1);

    typedef struct packed {
        instr_type_e        kind;
        dma_instruction     dma;
        math_instr          math;
        regfile_instruction cache;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] dmaOutstanding;
    logic          busy;
    logic          err;
`ifdef IQ_DISPATCH_PERF_EN
    logic [31:0]   stallDma, stallCache, issuedCount;
`endif

    iq_dispatch_if ifc();

    iq_dispatch #(.DMA_MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (ifc.master),
        .dma_outstanding_o (dmaOutstanding),
        .busy_o            (busy),
        .err_o             (err)
`ifdef IQ_DISPATCH_PERF_EN
        ,
        .stall_dma_cycles_o   (stallDma),
        .stall_cache_cycles_o (stallCache),
        .issued_count_o       (issuedCount)
`endif
    );

    always #5 clk = ~clk;

    entry_t iqModel[$];
    entry_t expQ[$];
    int     compared   = 0;
    int     mismatched = 0;
    int     tbCount    = 0;
    bit     reRecorded = 1'b0;
    bit     randomMode = 1'b0;
    bit     anyRsvd    = 1'b0;
    entry_t reluEntry;
    entry_t tmpEntry;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic entry_t makeEntry(input instr_type_e k);
        entry_t e;
        e.kind          = k;
        e.dma.srcAddr   = 16'($urandom);
        e.dma.dstAddr   = 16'($urandom);
        e.dma.length    = 8'($urandom);
        e.math.op       = math_op_e'($urandom_range(0, 3));
        e.math.operand  = 10'($urandom);
        e.cache.isStore = 1'($urandom);
        e.cache.regIdx  = 5'($urandom);
        e.cache.addr    = 16'($urandom);
        return e;
    endfunction

    // Queue an instruction: the queue model gets it, and so does the expected issue stream unless reserved.
    task automatic applyStimulus(input entry_t e);
        @(negedge clk);
        #2;
        iqModel.push_back(e);
        if (e.kind != INSTR_TYPE_RSVD) expQ.push_back(e);
        ifc.iq_empty = 1'b0;
    endtask

    task automatic pulseDone();
        @(negedge clk);
        ifc.dma_done = 1'b1;
        @(negedge clk);
        ifc.dma_done = 1'b0;
    endtask

    task automatic waitForMathValid(input string name);
        for (int i = 0; i < 20 && !ifc.math_valid; i++) begin
            @(negedge clk);
            #4;
        end
        checkOutput(name, 64'(ifc.math_valid), 64'(1));
    endtask

    task automatic clearModels();
        iqModel.delete();
        expQ.delete();
        tbCount      = 0;
        ifc.iq_empty = 1'b1;
    endtask

    task automatic checkHandshake(input instr_type_e unit, input logic [63:0] payload);
        entry_t e;
        checkOutput("pending expectation", 64'(expQ.size() > 0), 64'(1));
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("issue unit", 64'(unit), 64'(e.kind));
            case (unit)
                INSTR_TYPE_DMA:        checkOutput("dma payload", payload, 64'(e.dma));
                INSTR_TYPE_ARITHMETIC: checkOutput("math payload", payload, 64'(e.math));
                default:               checkOutput("cache payload", payload, 64'(e.cache));
            endcase
        end
    endtask

    // Queue model: data appears the cycle after a pop; iq_re is sampled just before the edge.
    initial begin
        entry_t head;
        forever begin
            @(negedge clk);
            if (reRecorded && iqModel.size() > 0) begin
                head               = iqModel.pop_front();
                ifc.iq_instr_type  = head.kind;
                ifc.iq_dma_instr   = head.dma;
                ifc.iq_math_instr  = head.math;
                ifc.iq_cache_instr = head.cache;
            end
            ifc.iq_empty = (iqModel.size() == 0);
            #4;
            reRecorded = ifc.iq_re;
        end
    end

    // Random readies and completion pulses, only while the random phase owns these inputs.
    initial begin
        forever begin
            @(negedge clk);
            if (randomMode) begin
                ifc.dma_ready   = 1'($urandom_range(0, 1));
                ifc.math_ready  = 1'($urandom_range(0, 1));
                ifc.cache_ready = 1'($urandom_range(0, 1));
                ifc.dma_done    = (tbCount > 0) && ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Monitor: every handshake is popped from the expected stream; ordering rules checked against the model count.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst_n) begin
                checkOutput("single valid",
                            64'((int'(ifc.dma_valid) + int'(ifc.math_valid) + int'(ifc.cache_valid)) <= 1), 64'(1));
                checkOutput("dma_outstanding", 64'(dmaOutstanding), 64'(tbCount));
                if (ifc.dma_valid && ifc.dma_ready) begin
                    checkOutput("dma credit cap", 64'(tbCount < MAX_OUT), 64'(1));
                    checkHandshake(INSTR_TYPE_DMA, 64'(ifc.dma_instr));
                end
                if (ifc.math_valid && ifc.math_ready) begin
                    checkHandshake(INSTR_TYPE_ARITHMETIC, 64'(ifc.math_instr));
                end
                if (ifc.cache_valid && ifc.cache_ready) begin
                    checkOutput("cache fence", 64'(tbCount == 0), 64'(1));
                    checkHandshake(INSTR_TYPE_LD_ST, 64'(ifc.cache_instr));
                end
                if (ifc.dma_valid && ifc.dma_ready) tbCount++;
                if (ifc.dma_done && tbCount > 0) tbCount--;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", compared);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n              = 1'b0;
        ifc.iq_empty       = 1'b1;
        ifc.iq_instr_type  = INSTR_TYPE_DMA;
        ifc.iq_dma_instr   = '0;
        ifc.iq_math_instr  = '0;
        ifc.iq_cache_instr = '0;
        ifc.dma_ready      = 1'b1;
        ifc.math_ready     = 1'b1;
        ifc.cache_ready    = 1'b1;
        ifc.dma_done       = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] reset state with empty queue");
        repeat (5) begin
            @(negedge clk);
            #4;
            checkOutput("reset iq_re", 64'(ifc.iq_re), 64'(0));
            checkOutput("reset dma_valid", 64'(ifc.dma_valid), 64'(0));
            checkOutput("reset math_valid", 64'(ifc.math_valid), 64'(0));
            checkOutput("reset cache_valid", 64'(ifc.cache_valid), 64'(0));
            checkOutput("reset busy", 64'(busy), 64'(0));
            checkOutput("reset err", 64'(err), 64'(0));
        end

        $display("[TB] single arithmetic pop");
        reluEntry              = makeEntry(INSTR_TYPE_ARITHMETIC);
        reluEntry.math.op      = MATH_RELU;
        reluEntry.math.operand = 10'h200;
        applyStimulus(reluEntry);
        #1;
        checkOutput("arith iq_re cycle1", 64'(ifc.iq_re), 64'(1));
        @(negedge clk); #4;
        checkOutput("arith RD iq_re", 64'(ifc.iq_re), 64'(0));
        checkOutput("arith RD math_valid", 64'(ifc.math_valid), 64'(0));
        @(negedge clk); #4;
        checkOutput("arith math_valid cycle3", 64'(ifc.math_valid), 64'(1));
        checkOutput("arith math_instr", 64'(ifc.math_instr), 64'(reluEntry.math));
        @(negedge clk); #4;
        checkOutput("arith idle busy", 64'(busy), 64'(0));

        $display("[TB] DMA credit cap");
        repeat (5) applyStimulus(makeEntry(INSTR_TYPE_DMA));
        repeat (14) @(negedge clk);
        #4;
        checkOutput("cap count", 64'(dmaOutstanding), 64'(MAX_OUT));
        checkOutput("cap fifth held", 64'(ifc.dma_valid), 64'(0));
        checkOutput("cap busy", 64'(busy), 64'(1));
        @(negedge clk);
        ifc.dma_done = 1'b1;
        @(negedge clk);
        ifc.dma_done = 1'b0;
        #4;
        checkOutput("cap fifth issues", 64'(ifc.dma_valid), 64'(1));
        @(negedge clk); #4;
        checkOutput("cap count again", 64'(dmaOutstanding), 64'(MAX_OUT));
        repeat (MAX_OUT) pulseDone();
        repeat (2) @(negedge clk);

        $display("[TB] cache fence behind DMA");
        applyStimulus(makeEntry(INSTR_TYPE_DMA));
        applyStimulus(makeEntry(INSTR_TYPE_LD_ST));
        repeat (10) begin
            @(negedge clk); #4;
            checkOutput("fence hold", 64'(ifc.cache_valid), 64'(0));
        end
        @(negedge clk);
        ifc.dma_done = 1'b1;
        #4;
        checkOutput("fence done cycle", 64'(ifc.cache_valid), 64'(0));
        @(negedge clk);
        ifc.dma_done = 1'b0;
        #4;
        checkOutput("fence release", 64'(ifc.cache_valid), 64'(1));
        repeat (2) @(negedge clk);

        $display("[TB] math backpressure");
        ifc.math_ready = 1'b0;
        applyStimulus(reluEntry);
        applyStimulus(makeEntry(INSTR_TYPE_ARITHMETIC));
        waitForMathValid("bp valid rise");
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin
                @(negedge clk); #4;
            end
            checkOutput("bp valid held", 64'(ifc.math_valid), 64'(1));
            checkOutput("bp payload held", 64'(ifc.math_instr), 64'(reluEntry.math));
            checkOutput("bp iq_re low", 64'(ifc.iq_re), 64'(0));
        end
        @(negedge clk);
        ifc.math_ready = 1'b1;
        #4;
        checkOutput("bp handshake pop", 64'(ifc.iq_re), 64'(1));
        repeat (4) @(negedge clk);

        $display("[TB] completion at zero count");
        #4;
        checkOutput("err before underflow", 64'(err), 64'(0));
        pulseDone();
        #4;
        checkOutput("underflow err", 64'(err), 64'(1));
        checkOutput("underflow count", 64'(dmaOutstanding), 64'(0));
        @(negedge clk);
        rst_n = 1'b0;
        clearModels();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #4;
        checkOutput("err cleared by reset", 64'(err), 64'(0));

        $display("[TB] reserved type dropped");
        applyStimulus(makeEntry(INSTR_TYPE_RSVD));
        applyStimulus(makeEntry(INSTR_TYPE_ARITHMETIC));
        repeat (8) @(negedge clk);
        #4;
        checkOutput("rsvd err", 64'(err), 64'(1));
        checkOutput("rsvd next dispatched", 64'(expQ.size()), 64'(0));

        $display("[TB] async reset during issue");
        ifc.math_ready = 1'b0;
        applyStimulus(makeEntry(INSTR_TYPE_ARITHMETIC));
        waitForMathValid("areset valid rise");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("areset math_valid drop", 64'(ifc.math_valid), 64'(0));
        checkOutput("areset busy", 64'(busy), 64'(0));
        checkOutput("areset err", 64'(err), 64'(0));
        clearModels();
        ifc.math_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] randomized traffic");
        randomMode = 1'b1;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                tmpEntry = makeEntry(INSTR_TYPE_RSVD);
                anyRsvd  = 1'b1;
            end else begin
                tmpEntry = makeEntry(instr_type_e'($urandom_range(0, 2)));
            end
            applyStimulus(tmpEntry);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int i = 0; i < 4000; i++) begin
            if (expQ.size() == 0 && iqModel.size() == 0 && tbCount == 0 && !busy) break;
            @(negedge clk);
            #4;
        end
        randomMode = 1'b0;
        checkOutput("random drained",
                    64'(expQ.size() == 0 && iqModel.size() == 0 && tbCount == 0 && !busy), 64'(1));
        @(negedge clk);
        ifc.dma_done    = 1'b0;
        ifc.dma_ready   = 1'b1;
        ifc.math_ready  = 1'b1;
        ifc.cache_ready = 1'b1;
        #4;
        checkOutput("random err", 64'(err), 64'(anyRsvd));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
